// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: state encoding, default widths
// and a constant-foldable ceil(log2) helper.
package word_ser_pkg;

  localparam int unsigned DEF_WORD_W  = 16;
  localparam int unsigned DEF_CHUNK_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/word_serializer_chunk_mux.sv
// Combinational chunk selector: returns word[idx*CHUNK_W +: CHUNK_W].
module chunk_mux
  import word_ser_pkg::*;
#(
  parameter  int unsigned WORD_W  = DEF_WORD_W,
  parameter  int unsigned CHUNK_W = DEF_CHUNK_W,
  localparam int unsigned NCHUNK  = WORD_W / CHUNK_W,
  localparam int unsigned IDX_W   = clog2(NCHUNK)
) (
  input  logic [WORD_W-1:0]  word,
  input  logic [IDX_W-1:0]   idx,
  output logic [CHUNK_W-1:0] chunk
);

  // Out-of-range indices (non power-of-two NCHUNK) select zero.
  always_comb begin
    chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) chunk = word[i*CHUNK_W +: CHUNK_W];
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Splits a WORD_W word into WORD_W/CHUNK_W chunks over valid/ready, LSB- or MSB-first.
// Optional WORD_SER_PARITY_EN adds out_parity (XOR of out_data).
module word_serializer
  import word_ser_pkg::*;
#(
  parameter  int unsigned WORD_W  = DEF_WORD_W,
  parameter  int unsigned CHUNK_W = DEF_CHUNK_W,
  localparam int unsigned NCHUNK  = WORD_W / CHUNK_W,
  localparam int unsigned IDX_W   = clog2(NCHUNK)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_msb_first,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
`ifdef WORD_SER_PARITY_EN
  ,
  output logic               out_parity
`endif
);

  if ((WORD_W % CHUNK_W) != 0 || NCHUNK < 2) begin : g_bad_cfg
    $error("word_serializer: WORD_W must be a multiple of CHUNK_W with at least 2 chunks");
  end

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic                msb_q, msb_d;
  logic                last;
  logic [IDX_W-1:0]    idx;
  logic [CHUNK_W-1:0]  chunk;

  assign last = (state == ST_SEND) && (cnt_q == IDX_W'(NCHUNK - 1));
  assign idx  = msb_q ? (IDX_W'(NCHUNK - 1) - cnt_q) : cnt_q;

  chunk_mux #(
    .WORD_W  (WORD_W),
    .CHUNK_W (CHUNK_W)
  ) u_chunk_mux (
    .word  (word_q),
    .idx   (idx),
    .chunk (chunk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      word_q <= '0;
      cnt_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      word_q <= word_d;
      cnt_q  <= cnt_d;
      msb_q  <= msb_d;
    end
  end

  // in_ready also opens on the last accepted beat so the next word loads with no bubble.
  always_comb begin
    state_nxt = state;
    word_d    = word_q;
    cnt_d     = cnt_q;
    msb_d     = msb_q;
    out_valid = (state == ST_SEND);
    in_ready  = (state == ST_IDLE) || (out_valid && out_ready && last);
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          word_d    = in_data;
          msb_d     = in_msb_first;
          cnt_d     = '0;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (last) begin
            if (in_valid) begin
              word_d = in_data;
              msb_d  = in_msb_first;
              cnt_d  = '0;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are forced to zero outside SEND so a finished word never lingers.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (state == ST_SEND) begin
      out_data = chunk;
      out_idx  = idx;
      out_last = last;
    end
  end

`ifdef WORD_SER_PARITY_EN
  assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: 16-bit (default) and 32-bit instances.
module tb_word_serializer;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_msb, a_out_valid, a_out_ready, a_out_last;
  logic [15:0] a_in_data;
  logic [7:0]  a_out_data;
  logic [0:0]  a_out_idx;
`ifdef WORD_SER_PARITY_EN
  logic        a_out_parity, b_out_parity;
`endif

  logic        b_in_valid, b_in_ready, b_msb, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_idx;

  beat_t qa[$];
  beat_t qb[$];
  int checks = 0;
  int errors = 0;

  word_serializer dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (a_in_valid),
    .in_ready     (a_in_ready),
    .in_data      (a_in_data),
    .in_msb_first (a_msb),
    .out_valid    (a_out_valid),
    .out_ready    (a_out_ready),
    .out_data     (a_out_data),
    .out_idx      (a_out_idx),
    .out_last     (a_out_last)
`ifdef WORD_SER_PARITY_EN
    ,
    .out_parity   (a_out_parity)
`endif
  );

  word_serializer #(.WORD_W(32), .CHUNK_W(8)) dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .in_data      (b_in_data),
    .in_msb_first (b_msb),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .out_data     (b_out_data),
    .out_idx      (b_out_idx),
    .out_last     (b_out_last)
`ifdef WORD_SER_PARITY_EN
    ,
    .out_parity   (b_out_parity)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 16'h0; a_msb = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 32'h0; b_msb = 0; b_out_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00 ||
        a_out_idx !== 1'b0 || a_out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset16: valid=%b ready=%b data=%h idx=%0d last=%b, need 0 1 00 0 0",
               a_out_valid, a_in_ready, a_out_data, a_out_idx, a_out_last);
    end
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset32: valid=%b ready=%b data=%h, need 0 1 00", b_out_valid, b_in_ready, b_out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00 ||
        b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: a_valid=%b a_ready=%b a_data=%h b_valid=%b b_ready=%b, need 0 1 00 0 1",
               a_out_valid, a_in_ready, a_out_data, b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_lsb_first();
    beat_t exp;
    int n = 0;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = 16'hA55A; a_msb = 0; a_out_ready = 1;
    qa.push_back(beat_t'{d: 8'h5A, idx: 2'd0, last: 1'b0});
    qa.push_back(beat_t'{d: 8'hA5, idx: 2'd1, last: 1'b1});
    @(posedge clk); #1 a_in_valid = 0; a_in_data = 16'hFFFF; a_msb = 1;
    for (int cyc = 0; cyc < 8 && qa.size() > 0; cyc++) begin
      @(negedge clk);
      if (a_out_valid === 1'b1) begin
        exp = qa.pop_front();
        checks++;
        if (a_out_data !== exp.d || {1'b0, a_out_idx} !== exp.idx || a_out_last !== exp.last || cyc != n) begin
          errors++;
          $display("FAIL lsb_beat%0d: data=%h idx=%0d last=%b cyc=%0d, need %h %0d %b cyc=%0d",
                   n, a_out_data, a_out_idx, a_out_last, cyc, exp.d, exp.idx, exp.last, n);
        end
        n++;
      end
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL lsb_timeout: %0d beats missing, need 0", qa.size());
      qa.delete();
    end
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL lsb_idle: valid=%b ready=%b, need 0 1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_msb_first32();
    beat_t exp;
    int n = 0;
    @(posedge clk); #1;
    b_in_valid = 1; b_in_data = 32'h11223344; b_msb = 1; b_out_ready = 1;
    qb.push_back(beat_t'{d: 8'h11, idx: 2'd3, last: 1'b0});
    qb.push_back(beat_t'{d: 8'h22, idx: 2'd2, last: 1'b0});
    qb.push_back(beat_t'{d: 8'h33, idx: 2'd1, last: 1'b0});
    qb.push_back(beat_t'{d: 8'h44, idx: 2'd0, last: 1'b1});
    @(posedge clk); #1 b_in_valid = 0; b_in_data = 32'h0; b_msb = 0;
    for (int cyc = 0; cyc < 12 && qb.size() > 0; cyc++) begin
      @(negedge clk);
      if (b_out_valid === 1'b1) begin
        exp = qb.pop_front();
        checks++;
        if (b_out_data !== exp.d || b_out_idx !== exp.idx || b_out_last !== exp.last || cyc != n) begin
          errors++;
          $display("FAIL msb32_beat%0d: data=%h idx=%0d last=%b cyc=%0d, need %h %0d %b cyc=%0d",
                   n, b_out_data, b_out_idx, b_out_last, cyc, exp.d, exp.idx, exp.last, n);
        end
        n++;
      end
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL msb32_timeout: %0d beats missing, need 0", qb.size());
      qb.delete();
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL msb32_idle: valid=%b ready=%b, need 0 1", b_out_valid, b_in_ready);
    end
  endtask

  task automatic test_backpressure();
    beat_t exp;
    int n = 0;
    @(posedge clk); #1;
    b_in_valid = 1; b_in_data = 32'hDEADBEEF; b_msb = 0; b_out_ready = 1;
    qb.push_back(beat_t'{d: 8'hEF, idx: 2'd0, last: 1'b0});
    qb.push_back(beat_t'{d: 8'hBE, idx: 2'd1, last: 1'b0});
    qb.push_back(beat_t'{d: 8'hAD, idx: 2'd2, last: 1'b0});
    qb.push_back(beat_t'{d: 8'hDE, idx: 2'd3, last: 1'b1});
    @(posedge clk); #1 b_in_valid = 0;
    @(negedge clk);
    exp = qb.pop_front();
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== exp.d || b_out_idx !== exp.idx || b_out_last !== exp.last) begin
      errors++;
      $display("FAIL bp_first: valid=%b data=%h idx=%0d last=%b, need 1 %h %0d %b",
               b_out_valid, b_out_data, b_out_idx, b_out_last, exp.d, exp.idx, exp.last);
    end
    @(posedge clk); #1 b_out_ready = 0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b1 || b_out_data !== qb[0].d || b_out_idx !== qb[0].idx ||
          b_out_last !== qb[0].last || b_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: valid=%b data=%h idx=%0d last=%b ready=%b, need 1 %h %0d %b 0",
                 s, b_out_valid, b_out_data, b_out_idx, b_out_last, b_in_ready, qb[0].d, qb[0].idx, qb[0].last);
      end
      @(posedge clk); #1 b_in_data = ~b_in_data; b_msb = ~b_msb;
    end
    b_out_ready = 1;
    for (int cyc = 0; cyc < 10 && qb.size() > 0; cyc++) begin
      @(negedge clk);
      if (b_out_valid === 1'b1) begin
        exp = qb.pop_front();
        checks++;
        if (b_out_data !== exp.d || b_out_idx !== exp.idx || b_out_last !== exp.last || cyc != n) begin
          errors++;
          $display("FAIL bp_resume%0d: data=%h idx=%0d last=%b cyc=%0d, need %h %0d %b cyc=%0d",
                   n, b_out_data, b_out_idx, b_out_last, cyc, exp.d, exp.idx, exp.last, n);
        end
        n++;
      end
    end
    checks++;
    if (qb.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout: %0d beats missing, need 0", qb.size());
      qb.delete();
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: valid=%b, need 0", b_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    beat_t exp;
    logic [15:0] words [2];
    logic acc;
    logic exp_valid, exp_ready;
    int sent = 0;
    int n = 0;
    words[0] = 16'h1234;
    words[1] = 16'h5678;
    qa.push_back(beat_t'{d: 8'h34, idx: 2'd0, last: 1'b0});
    qa.push_back(beat_t'{d: 8'h12, idx: 2'd1, last: 1'b1});
    qa.push_back(beat_t'{d: 8'h78, idx: 2'd0, last: 1'b0});
    qa.push_back(beat_t'{d: 8'h56, idx: 2'd1, last: 1'b1});
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = words[0]; a_msb = 0; a_out_ready = 1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      exp_valid = (cyc >= 1 && cyc <= 4);
      exp_ready = (cyc != 1 && cyc != 3);
      checks++;
      if (a_out_valid !== exp_valid || a_in_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_hs_cyc%0d: valid=%b ready=%b, need %b %b",
                 cyc, a_out_valid, a_in_ready, exp_valid, exp_ready);
      end
      if (a_out_valid === 1'b1 && qa.size() > 0) begin
        exp = qa.pop_front();
        checks++;
        if (a_out_data !== exp.d || {1'b0, a_out_idx} !== exp.idx || a_out_last !== exp.last) begin
          errors++;
          $display("FAIL b2b_beat%0d: data=%h idx=%0d last=%b, need %h %0d %b",
                   n, a_out_data, a_out_idx, a_out_last, exp.d, exp.idx, exp.last);
        end
        n++;
      end
      acc = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 2) a_in_data = words[sent];
        else a_in_valid = 0;
      end
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout: %0d beats missing, need 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic test_reset_mid_word();
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = 16'hBEEF; a_msb = 0; a_out_ready = 1;
    @(posedge clk); #1 a_in_valid = 0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== 8'hEF) begin
      errors++;
      $display("FAIL rst_mid_first: valid=%b data=%h, need 1 ef", a_out_valid, a_out_data);
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%b ready=%b data=%h, need 0 1 00", a_out_valid, a_in_ready, a_out_data);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (a_out_valid !== 1'b0 || a_out_data === 8'hBE) begin
        errors++;
        $display("FAIL rst_mid_after%0d: valid=%b data=%h, need 0 and no be", cyc, a_out_valid, a_out_data);
      end
    end
  endtask

`ifdef WORD_SER_PARITY_EN
  task automatic test_parity();
    logic exp_par;
    int n = 0;
    @(posedge clk); #1;
    a_in_valid = 1; a_in_data = 16'h075A; a_msb = 0; a_out_ready = 1;
    @(posedge clk); #1 a_in_valid = 0;
    for (int cyc = 0; cyc < 6 && n < 2; cyc++) begin
      @(negedge clk);
      if (a_out_valid === 1'b1) begin
        exp_par = (n == 0) ? 1'b0 : 1'b1;
        checks++;
        if (a_out_parity !== exp_par) begin
          errors++;
          $display("FAIL parity%0d: data=%h parity=%b, need %b", n, a_out_data, a_out_parity, exp_par);
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL parity_timeout: got %0d beats, need 2", n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first32();
    test_backpressure();
    test_back_to_back();
`ifdef WORD_SER_PARITY_EN
    test_parity();
`endif
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Parametrised successor to the fixed 16-to-2x8 word split.
- Accepts a WORD_W-bit word over a valid/ready handshake and emits it as WORD_W/CHUNK_W chunks over a second valid/ready handshake, one chunk per accepted beat.
- Chunk order is selectable per word: LSB-first or MSB-first.
- Sits between the processor datapath and narrow byte-wide consumers such as the UART/IO bridge or a byte-wide memory port.

Parameters:
- WORD_W, 16, input word width; must be an integer multiple of CHUNK_W.
- CHUNK_W, 8, output chunk width.
- NCHUNK, WORD_W/CHUNK_W, derived, not overridden; must be >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  WORD_W  input word.
- in_msb_first  in  1  sampled with the word: 1 = highest chunk first, 0 = chunk [CHUNK_W-1:0] first.
- out_valid  out  1  out_data holds a valid chunk.
- out_ready  in  1  consumer accepts the chunk.
- out_data  out  CHUNK_W  current chunk.
- out_idx  out  clog2(NCHUNK)  physical chunk index of out_data (0 = least-significant chunk).
- out_last  out  1  current chunk is the final chunk of the word.

Behaviour:
- Reset (async assert, sync release): state IDLE, word register 0, beat counter 0, mode 0. Outputs: out_valid 0, out_data 0, out_idx 0, out_last 0, in_ready 1.
- FSM:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_data and in_msb_first, clear the beat counter, go to SEND.
  - SEND: out_valid=1.
- out_data, out_idx and out_last are combinational from registered state only. No combinational path from in_* to out_*.
- Chunk selection:
  - LSB-first: idx = beat counter.
  - MSB-first: idx = NCHUNK-1-beat counter.
  - out_data = word[idx*CHUNK_W +: CHUNK_W].
  - out_last = (beat counter == NCHUNK-1).
- Beat accept = out_valid && out_ready. On accept, the counter increments if not last.
- On accept of the last beat:
  - If in_valid=1 in the same cycle, the new word is latched, the counter clears and the FSM stays in SEND (back-to-back, zero bubble).
  - Otherwise the FSM goes to IDLE.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This combinational path from out_ready to in_ready is permitted.
- Hold rule: while out_valid=1 and out_ready=0, out_data, out_idx and out_last are stable. in_data changes have no effect after latch.
- Latency: word accepted at edge N gives its first chunk valid in cycle N+1. Throughput is NCHUNK beats per word, sustained.
- Reset mid-word: the partial word is discarded and out_valid drops immediately (async). No chunks from the old word appear after reset.
- in_msb_first is ignored when no input accept occurs.

Optional Feature:
- Macro WORD_SER_PARITY_EN.
- Defined: adds output port out_parity (1 bit) = even parity (XOR reduction) of out_data, valid whenever out_valid=1. Resets to 0.
- Undefined: port and logic absent; the block is otherwise identical.

Decomposition:
- Shared package word_ser_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SEND=1'b1;
  - the clog2 helper function;
  - default WORD_W/CHUNK_W constants.
- One sub-module, chunk_mux: purely combinational. Parametrised WORD_W/CHUNK_W, takes word and idx, returns the chunk. It replaces the fixed low/high slice.
- FSM, counter and handshake stay in word_serializer.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> out_valid=0, in_ready=1, out_data=0. After release with no in_valid, nothing changes.
- LSB-first, out_ready held 1: in_data=16'hA55A, in_msb_first=0 -> chunks 8'h5A (idx0, last0) then 8'hA5 (idx1, last1), on consecutive cycles, then IDLE.
- MSB-first, WORD_W=32: in_data=32'h11223344, in_msb_first=1 -> 8'h11, 8'h22, 8'h33, 8'h44 with idx 3,2,1,0; last only on 8'h44.
- Backpressure: out_ready=0 for 4 cycles mid-word with in_data toggled -> out_data and out_idx frozen, in_ready=0. On release, the remaining chunks come out in order.
- Back-to-back: words 16'h1234 then 16'h5678 offered continuously with out_ready=1 -> output 34,12,78,56 with no idle cycle. in_ready pulses only on the last-beat cycle.
- Reset mid-word: assert rst_n low after the first chunk of 16'hBEEF -> out_valid=0 immediately. After release, 8'hBE never appears.
- With WORD_SER_PARITY_EN: chunk 8'h5A gives out_parity=0; 8'h07 gives out_parity=1.
